// File: rtl/lc3_mem_responder.sv
// rtl/lc3_mem_responder.sv - LC-3 memory responder: word RAM, KBSR/KBDR/DSR/DDR/MCR, R handshake, INT.
// Optional macro LC3_DISP_INT_EN adds the display interrupt enable DSR[14].
module lc3_mem_responder #(
  parameter int MEM_AW  = 12,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic [15:0] mar,
  input  logic [15:0] mdr_in,
  output logic [15:0] mdr_out,
  output logic        R,
  output logic        INT,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ready,
  output logic        mcr_run
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] LOAD = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  count;
  logic        lat_rw;
  logic [15:0] lat_addr;
  logic [15:0] lat_data;
  logic        kb_ready;
  logic        kb_ie;
  logic [7:0]  kb_char;
  logic [15:0] ram [2**MEM_AW];

  logic        commit;
  logic        c_rw;
  logic [15:0] c_addr;
  logic [15:0] c_data;
  logic [15:0] rdata;
  logic        dsr14;
  logic        int_next;

  // With LATENCY=1 the capture edge is also the commit edge, so commit uses the live inputs.
  always_comb begin
    commit = 1'b0;
    c_rw   = lat_rw;
    c_addr = lat_addr;
    c_data = lat_data;
    if (state == IDLE && mio_en && LOAD == 4'd0) begin
      commit = 1'b1;
      c_rw   = r_w;
      c_addr = mar;
      c_data = mdr_in;
    end else if (state == BUSY && count == 4'd1) begin
      commit = 1'b1;
    end
  end

  logic is_ram;
  logic wr;
  logic rd;
  assign is_ram = (c_addr < 16'hFE00);
  assign wr     = commit & c_rw & ~reset;
  assign rd     = commit & ~c_rw;

  logic kbsr_wr, kbdr_rd, ddr_wr, mcr_wr, dsr_wr, ram_wr;
  assign kbsr_wr = wr && c_addr == 16'hFE00;
  assign kbdr_rd = rd && c_addr == 16'hFE02;
  assign dsr_wr  = wr && c_addr == 16'hFE04;
  assign ddr_wr  = wr && c_addr == 16'hFE06;
  assign mcr_wr  = wr && c_addr == 16'hFFFE;
  assign ram_wr  = wr && is_ram;

`ifdef LC3_DISP_INT_EN
  logic ds_ie;
  assign dsr14    = ds_ie;
  assign int_next = (kb_ready & kb_ie) | (~disp_valid & ds_ie);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ds_ie <= 1'b0;
    else if (dsr_wr) ds_ie <= c_data[14];
  end
`else
  assign dsr14    = 1'b0;
  assign int_next = kb_ready & kb_ie;
  logic unused_dsr;
  assign unused_dsr = dsr_wr;
`endif

  always_comb begin
    rdata = 16'h0000;
    if (is_ram) begin
      rdata = ram[c_addr[MEM_AW-1:0]];
    end else begin
      case (c_addr)
        16'hFE00: rdata = {kb_ready, kb_ie, 14'b0};
        16'hFE02: rdata = {8'h00, kb_char};
        16'hFE04: rdata = {~disp_valid, dsr14, 14'b0};
        16'hFE06: rdata = {8'h00, disp_data};
        16'hFFFE: rdata = {mcr_run, 15'b0};
        default:  rdata = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr) ram[c_addr[MEM_AW-1:0]] <= c_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= 4'd0;
      lat_rw     <= 1'b0;
      lat_addr   <= 16'h0000;
      lat_data   <= 16'h0000;
      R          <= 1'b0;
      mdr_out    <= 16'h0000;
      INT        <= 1'b0;
      kb_ready   <= 1'b0;
      kb_ie      <= 1'b0;
      kb_char    <= 8'h00;
      disp_valid <= 1'b0;
      disp_data  <= 8'h00;
      mcr_run    <= 1'b1;
    end else begin
      R   <= 1'b0;
      INT <= int_next;

      case (state)
        IDLE: begin
          if (mio_en) begin
            lat_rw   <= r_w;
            lat_addr <= mar;
            lat_data <= mdr_in;
            count    <= LOAD;
            if (LOAD == 4'd0) begin
              state <= RESP;
              R     <= 1'b1;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state <= RESP;
            R     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (rd) mdr_out <= rdata;
      if (kbsr_wr) kb_ie <= c_data[14];
      if (mcr_wr) mcr_run <= c_data[15];

      // A fresh character arriving with a KBDR read replaces the one being consumed.
      if (kb_valid && (!kb_ready || kbdr_rd)) begin
        kb_char  <= kb_data;
        kb_ready <= 1'b1;
      end else if (kbdr_rd) begin
        kb_ready <= 1'b0;
      end

      if (ddr_wr && (!disp_valid || disp_ready)) begin
        disp_data  <= c_data[7:0];
        disp_valid <= 1'b1;
      end else if (disp_valid && disp_ready) begin
        disp_valid <= 1'b0;
      end
    end
  end

endmodule
